wb_merge_buffer: RTL

- Writeback-side stage directly upstream of the 4-read/1-write register file.
- Takes up to two writeback results per cycle (pipe 0 and pipe 1 of the dual-issue core) into an in-order queue and drains one per cycle into the single regfile write port.
- Forwards the youngest pending value for each of the four regfile read addresses, so decode never reads stale data.

---
 rtl/wb_merge_buffer_pkg.sv | 16 +
 rtl/wb_fwd_match.sv | 37 +++
 rtl/wb_merge_buffer.sv | 97 +++++++++
 3 files changed

// File: rtl/wb_merge_buffer_pkg.sv
// Shared constants and bus types for the writeback merge buffer slice.
// Parameter defaults for the buffer and its forwarding matchers live here.
package wb_merge_buffer_pkg;

  localparam int REG_AW        = 5;
  localparam int DATA_W        = 32;
  localparam int DEFAULT_DEPTH = 4;
  localparam int WB_BUS_W      = 1 + REG_AW + DATA_W;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_bus_t;

endpackage

// File: rtl/wb_fwd_match.sv
// One forwarding lookup port: finds the youngest pending entry whose
// destination matches raddr and returns its data (0 on no hit).
module wb_fwd_match
  import wb_merge_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = REG_AW,
  parameter int DW    = DATA_W
) (
  input  logic [DEPTH-1:0][AW-1:0] entry_addr,
  input  logic [DEPTH-1:0][DW-1:0] entry_data,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            raddr,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (entry_addr[idx] == raddr) && (raddr != '0)) begin
        hit  = 1'b1;
        data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/wb_merge_buffer.sv
// Dual-input writeback queue draining one entry per cycle into the regfile
// write port, with youngest-value forwarding for the four read ports.
module wb_merge_buffer
  import wb_merge_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = REG_AW,
  parameter int DW    = DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb0_we,
  input  logic [AW-1:0]          wb0_waddr,
  input  logic [DW-1:0]          wb0_wdata,
  input  logic                   wb1_we,
  input  logic [AW-1:0]          wb1_waddr,
  input  logic [DW-1:0]          wb1_wdata,
  output logic                   in_ready,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_waddr,
  output logic [DW-1:0]          rf_wdata,
  input  logic [4*AW-1:0]        q_raddr,
  output logic [3:0]             q_hit,
  output logic [4*DW-1:0]        q_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] mem_addr;
  logic [DEPTH-1:0][DW-1:0] mem_data;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [PW-1:0]            tail_p1;
  logic [CW-1:0]            cnt;
  logic                     v0;
  logic                     v1;
  logic                     pop;
  logic [1:0]               n_push;

  // Writes to r0 carry no information, so they never take a slot.
  assign v0       = wb0_we && (wb0_waddr != '0);
  assign v1       = wb1_we && (wb1_waddr != '0);
  assign in_ready = (cnt <= CW'(DEPTH - 2));
  assign pop      = (cnt != '0);
  assign n_push   = in_ready ? ({1'b0, v0} + {1'b0, v1}) : 2'd0;
  assign tail_p1  = tail + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(pop);
      tail <= tail + PW'(n_push);
      cnt  <= cnt + CW'(n_push) - CW'(pop);
    end
  end

  // Entry storage needs no reset: only slots between head and tail are read.
  always_ff @(posedge clk) begin
    if (in_ready) begin
      if (v0) begin
        mem_addr[tail] <= wb0_waddr;
        mem_data[tail] <= wb0_wdata;
      end
      if (v1) begin
        mem_addr[v0 ? tail_p1 : tail] <= wb1_waddr;
        mem_data[v0 ? tail_p1 : tail] <= wb1_wdata;
      end
    end
  end

  assign rf_we    = pop;
  assign rf_waddr = pop ? mem_addr[head] : '0;
  assign rf_wdata = pop ? mem_data[head] : '0;
  assign count    = cnt;

  for (genvar g = 0; g < 4; g++) begin : g_fwd
    wb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
    ) u_match (
      .entry_addr (mem_addr),
      .entry_data (mem_data),
      .head       (head),
      .count      (cnt),
      .raddr      (q_raddr[g*AW +: AW]),
      .hit        (q_hit[g]),
      .data       (q_data[g*DW +: DW])
    );
  end

endmodule
